// File: rtl/tx_frame_sched.sv
// Frame scheduler ahead of pam_map: round-robin arbitration of two AXI-Stream sources,
// whole-frame grants, max-length truncation with drain, and a forced inter-frame gap.
module tx_frame_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned IFG_CYCLES = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    en,
  input  logic                    clr_err,
  input  logic [DATA_WIDTH-1:0]   s0_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
  input  logic                    s0_tlast,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic [DATA_WIDTH-1:0]   s1_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
  input  logic                    s1_tlast,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [1:0]              grant,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    frame_cnt,
  output logic                    err_trunc
);

  localparam int unsigned KeepWidth = DATA_WIDTH / 8;
  localparam int unsigned WcWidth   = $clog2(MAX_WORDS + 1);
  localparam int unsigned GapWidth  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [WcWidth-1:0]  MaxLast = WcWidth'(MAX_WORDS - 1);
  localparam logic [GapWidth-1:0] GapLast = GapWidth'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StXfer, StDrop, StGap} state_e;

  // With no gap configured a finished frame returns straight to arbitration.
  localparam state_e FrameEndSt = (IFG_CYCLES == 0) ? StIdle : StGap;

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  rr_s1_q, rr_s1_d;
  logic [WcWidth-1:0]    word_cnt_q, word_cnt_d;
  logic [GapWidth-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic                  err_q, err_d;

  logic                  pick_s1;
  logic [DATA_WIDTH-1:0] src_tdata;
  logic [KeepWidth-1:0]  src_tkeep;
  logic                  src_tlast;
  logic                  src_tvalid;
  logic                  at_max;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      grant_q     <= 2'b00;
      rr_s1_q     <= 1'b1;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_s1_q     <= rr_s1_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  // Source mux is driven by the latched grant only, so it is stable for the whole frame.
  always_comb begin
    if (grant_q[1]) begin
      src_tdata  = s1_tdata;
      src_tkeep  = s1_tkeep;
      src_tlast  = s1_tlast;
      src_tvalid = s1_tvalid;
    end else begin
      src_tdata  = s0_tdata;
      src_tkeep  = s0_tkeep;
      src_tlast  = s0_tlast;
      src_tvalid = s0_tvalid;
    end
  end

  assign at_max = (word_cnt_q == MaxLast);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_s1_d     = rr_s1_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = clr_err ? 1'b0 : err_q;
    pick_s1     = 1'b0;
    m_tdata     = '0;
    m_tkeep     = '0;
    m_tlast     = 1'b0;
    m_tvalid    = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en && (s0_tvalid || s1_tvalid)) begin
          pick_s1    = (s0_tvalid && s1_tvalid) ? rr_s1_q : s1_tvalid;
          grant_d    = pick_s1 ? 2'b10 : 2'b01;
          rr_s1_d    = ~pick_s1;
          word_cnt_d = '0;
          state_d    = StXfer;
        end
      end

      StXfer: begin
        m_tdata   = src_tdata;
        m_tkeep   = src_tkeep;
        m_tlast   = src_tlast | at_max;
        m_tvalid  = src_tvalid;
        s0_tready = grant_q[0] & m_tready;
        s1_tready = grant_q[1] & m_tready;
        if (src_tvalid && m_tready) begin
          if (src_tlast || at_max) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            word_cnt_d  = '0;
            if (src_tlast) begin
              state_d   = FrameEndSt;
              gap_cnt_d = '0;
            end else begin
              // Truncation overrides a same-cycle clr_err.
              err_d   = 1'b1;
              state_d = StDrop;
            end
          end else begin
            word_cnt_d = word_cnt_q + WcWidth'(1);
          end
        end
      end

      StDrop: begin
        s0_tready = grant_q[0];
        s1_tready = grant_q[1];
        if (src_tvalid && src_tlast) begin
          state_d   = FrameEndSt;
          gap_cnt_d = '0;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapWidth'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign grant     = ((state_q == StXfer) || (state_q == StDrop)) ? grant_q : 2'b00;
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;
  assign err_trunc = err_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed plus randomized bench for tx_frame_sched; expected output comes from a
// frame-level round-robin model fed with the same frames as the source drivers.
module tb_tx_frame_sched;
  localparam int unsigned DW   = 32;
  localparam int unsigned KW   = DW / 8;
  localparam int unsigned MAXW = 8;
  localparam int unsigned IFG  = 16;
  localparam int unsigned CW   = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0, m_tdata;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0, m_tkeep;
  logic          s0_tlast = 1'b0, s0_tvalid = 1'b0, s0_tready;
  logic          s1_tlast = 1'b0, s1_tvalid = 1'b0, s1_tready;
  logic          m_tlast, m_tvalid;
  logic          m_tready = 1'b0;
  logic [1:0]    grant;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic          err_trunc;

  tx_frame_sched #(
    .DATA_WIDTH(DW), .MAX_WORDS(MAXW), .IFG_CYCLES(IFG), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .clr_err(clr_err),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant(grant), .busy(busy), .frame_cnt(frame_cnt), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  beat_t       s0_q[$], s1_q[$];   // beats still to be offered by each source
  beat_t       m0_q[$], m1_q[$];   // model copies of the same beats
  int unsigned l0_q[$], l1_q[$];   // model frame lengths per source
  beat_t       exp_q[$], out_q[$];
  int          exp_grant_q[$], got_grant_q[$];
  int          gap_q[$];
  int          model_pref_s1 = 1;
  int unsigned model_cnt = 0;
  logic        model_err = 1'b0;
  int          rdy_mode = 0;       // 0: always ready, 1: toggle, 2: random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_frame(input int src, input int unsigned len);
    beat_t b;
    for (int unsigned i = 0; i < len; i++) begin
      b.d = $urandom;
      b.k = KW'($urandom);
      b.l = (i == len - 1);
      if (src == 1) begin
        s1_q.push_back(b);
        m1_q.push_back(b);
      end else begin
        s0_q.push_back(b);
        m0_q.push_back(b);
      end
    end
    if (src == 1) l1_q.push_back(len);
    else l0_q.push_back(len);
  endtask

  // Whole-frame round robin: the source not granted last time wins a tie.
  task automatic run_model();
    int          g;
    int unsigned len;
    beat_t       b;
    while (l0_q.size() != 0 || l1_q.size() != 0) begin
      if (l0_q.size() != 0 && l1_q.size() != 0) g = model_pref_s1;
      else g = (l1_q.size() != 0) ? 1 : 0;
      model_pref_s1 = (g == 0) ? 1 : 0;
      len = (g == 1) ? l1_q.pop_front() : l0_q.pop_front();
      for (int unsigned i = 0; i < len; i++) begin
        b = (g == 1) ? m1_q.pop_front() : m0_q.pop_front();
        if (i < MAXW) begin
          if (i == MAXW - 1) b.l = 1'b1;
          exp_q.push_back(b);
        end
      end
      if (len > MAXW) model_err = 1'b1;
      model_cnt++;
      exp_grant_q.push_back(g);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (s0_q.size() == 0 && s1_q.size() == 0 && !busy && exp_q.size() == out_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    check({tag, "_done"}, 64'(ok), 64'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_nbeats"}, 64'(out_q.size()), 64'(exp_q.size()));
    while (exp_q.size() != 0 && out_q.size() != 0)
      check({tag, "_beat"}, 64'(out_q.pop_front()), 64'(exp_q.pop_front()));
    check({tag, "_nframes"}, 64'(got_grant_q.size()), 64'(exp_grant_q.size()));
    while (exp_grant_q.size() != 0 && got_grant_q.size() != 0)
      check({tag, "_grant"}, 64'(got_grant_q.pop_front()), 64'(exp_grant_q.pop_front()));
    while (gap_q.size() != 0) check({tag, "_ifg"}, 64'(gap_q.pop_front()), 64'(IFG));
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(model_cnt[CW-1:0]));
    check({tag, "_err_trunc"}, 64'(err_trunc), 64'(model_err));
    exp_q.delete(); out_q.delete(); exp_grant_q.delete(); got_grant_q.delete();
  endtask

  task automatic flush_all();
    s0_q.delete(); s1_q.delete(); m0_q.delete(); m1_q.delete();
    l0_q.delete(); l1_q.delete(); exp_q.delete(); out_q.delete();
    exp_grant_q.delete(); got_grant_q.delete(); gap_q.delete();
    model_pref_s1 = 1;
    model_cnt     = 0;
    model_err     = 1'b0;
  endtask

  // Source/sink driver and output monitor: samples at negedge, drives just after posedge.
  initial begin : bfm
    logic          hs0, hs1, hsm, in_frame, prev_stall;
    logic [63:0]   prev_m;
    int            gap_run;
    in_frame = 1'b0; prev_stall = 1'b0; prev_m = '0; gap_run = 0;
    forever begin
      @(negedge clk);
      hs0 = s0_tvalid && s0_tready;
      hs1 = s1_tvalid && s1_tready;
      hsm = m_tvalid && m_tready;
      if (arst_n) begin
        if (prev_stall) check("axi_hold", {26'd0, m_tvalid, m_tlast, m_tkeep, m_tdata}, prev_m);
        prev_stall = m_tvalid && !m_tready;
        prev_m     = {26'd0, m_tvalid, m_tlast, m_tkeep, m_tdata};
        if (hsm) begin
          out_q.push_back({m_tdata, m_tkeep, m_tlast});
          if (!in_frame) got_grant_q.push_back((grant == 2'b10) ? 1 : 0);
          in_frame = !m_tlast;
        end
        if (busy && grant == 2'b00) gap_run++;
        else if (gap_run != 0) begin
          gap_q.push_back(gap_run);
          gap_run = 0;
        end
      end else begin
        in_frame = 1'b0; prev_stall = 1'b0; gap_run = 0;
      end
      @(posedge clk);
      #1;
      if (hs0 === 1'b1 && s0_q.size() != 0) void'(s0_q.pop_front());
      if (hs1 === 1'b1 && s1_q.size() != 0) void'(s1_q.pop_front());
      s0_tvalid = (s0_q.size() != 0);
      {s0_tdata, s0_tkeep, s0_tlast} = (s0_q.size() != 0) ? s0_q[0] : '0;
      s1_tvalid = (s1_q.size() != 0);
      {s1_tdata, s1_tkeep, s1_tlast} = (s1_q.size() != 0) ? s1_q[0] : '0;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    logic seen_busy;
    // Reset state
    repeat (3) tick();
    check("rst_outputs", {busy, grant, frame_cnt, err_trunc, s0_tready, s1_tready, m_tvalid},
          '0);
    arst_n = 1'b1;
    en     = 1'b1;
    tick();

    // T2: one 4-beat S0 frame; arbitration + 4 beats + gap
    add_frame(0, 4);
    run_model();
    n = 0;
    seen_busy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy || s0_tvalid) n++;
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !busy && !s0_tvalid) break;
    end
    check("t2_window", 64'(n), 64'(1 + 4 + IFG));
    wait_done("t2", 50);
    compare("t2");

    // T3: both sources continuously valid, 2-beat frames
    add_frame(0, 2); add_frame(0, 2);
    add_frame(1, 2); add_frame(1, 2);
    run_model();
    wait_done("t3", 300);
    check("t3_ngaps", 64'(gap_q.size()), 64'd4);
    compare("t3");

    // T4: toggling m_tready, frame exactly MAX_WORDS long
    rdy_mode = 1;
    add_frame(0, 8);
    run_model();
    wait_done("t4", 200);
    compare("t4");

    // T5: 12-beat S1 frame truncated at 8, tail drained
    rdy_mode = 0;
    add_frame(1, 12);
    run_model();
    wait_done("t5", 200);
    compare("t5");
    repeat (5) tick();
    check("t5_err_sticky", 64'(err_trunc), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    model_err = 1'b0;
    check("t5_err_clr", 64'(err_trunc), 64'd0);

    // T6: en dropped mid-frame; frame finishes, nothing new granted
    add_frame(0, 6);
    run_model();
    for (int c = 0; c < 50 && out_q.size() < 2; c++) tick();
    check("t6_started", 64'(out_q.size() >= 2), 64'd1);
    en = 1'b0;
    add_frame(1, 3);
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!busy && s0_q.size() == 0 && out_q.size() == exp_q.size()) break;
    end
    tick();
    compare("t6a");
    repeat (30) tick();
    check("t6_no_grant", 64'({busy, 8'(s1_q.size())}), 64'd3);
    en = 1'b1;
    run_model();
    wait_done("t6b", 100);
    compare("t6b");

    // T1: reset mid-traffic, then first contended grant goes to S1
    rdy_mode = 1;
    add_frame(0, 8);
    add_frame(1, 8);
    repeat (6) tick();
    arst_n = 1'b0;
    tick();
    check("t1_rst_now", {busy, grant, frame_cnt, err_trunc, s0_tready, s1_tready, m_tvalid},
          '0);
    tick();
    tick();
    check("t1_rst_held", {busy, grant, frame_cnt, err_trunc, s0_tready, s1_tready, m_tvalid},
          '0);
    flush_all();
    tick();
    arst_n = 1'b1;
    tick();
    add_frame(0, 2);
    add_frame(1, 3);
    run_model();
    wait_done("t1", 200);
    compare("t1");

    // Randomized rounds against the frame-level model
    rdy_mode = 2;
    for (int r = 0; r < 5; r++) begin
      for (int f = $urandom_range(0, 3); f > 0; f--) add_frame(0, $urandom_range(1, 12));
      for (int f = $urandom_range(1, 3); f > 0; f--) add_frame(1, $urandom_range(1, 12));
      run_model();
      wait_done("rnd", 3000);
      compare("rnd");
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      model_err = 1'b0;
      check("rnd_err_clr", 64'(err_trunc), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
